coeff_ram_arbiter: RTL and testbench
====================================

# coeff_ram_arbiter

Shares the single coefficient RAM (RAM_S, `s_size` words) between the three command engines: STP writes, EVP reads and EVB reads. It replaces direct multi-driving of the RAM_S port with a registered request/grant handshake and round-robin fairness. It also provides a per-requester read-valid strobe that aligns with the RAM's one-cycle read latency. It sits inside the firing-state controller, between the command FSMs and RAM_S.

## Interface
Parameters:
- `word_size`, 16, coefficient width
- `s_size`, 88, RAM_S depth in words
- `max_burst`, 16, cycles a grant may be held while another request waits (used only with `ARB_BURST_LIMIT_EN`)

Ports (`aw` = log2(`s_size`) = 7; index 0 = STP, 1 = EVP, 2 = EVB):
- `clk`  in  1  system clock. One clock domain; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset
- `req`  in  3  access request, one bit per requester
- `addr_in`  in  3*aw  packed addresses; requester i uses bits [i*aw +: aw]
- `rd_en_in`  in  3  read strobe per requester
- `wr_en_in`  in  3  write strobe per requester
- `wr_data_in`  in  3*word_size  packed write data
- `grant`  out  3  one-hot grant
- `rd_valid`  out  3  read data valid for requester i
- `ram_addr`  out  aw  RAM_S address
- `ram_rd_en`  out  1  RAM_S read enable
- `ram_wr_en`  out  1  RAM_S write enable
- `ram_wr_data`  out  word_size  RAM_S write data
- `addr_err`  out  1  one-cycle pulse when an out-of-range access is dropped

## Operation
State machine:
- IDLE: `grant` = 0. If any `req` bit is set, the round-robin winner is chosen, starting the search at `rr_ptr`. Next state is BUSY, with `grant` registered one-hot to the winner.
- BUSY: the RAM port is muxed combinationally from the granted requester.
  - `ram_rd_en` = `rd_en_in[g]`, `ram_wr_en` = `wr_en_in[g]`, `ram_addr` = `addr_in[g]`, `ram_wr_data` = `wr_data_in[g]`.
  - Strobes from requesters without a grant are ignored; no RAM access is issued for them.
  - When `req[g]` = 0, next state is IDLE, `grant` is cleared, and `rr_ptr` = (g+1) mod 3.
- Arbitration is fully registered: a new winner is never granted in the same cycle a grant is released. There is always at least one IDLE cycle between grants.
- Read routing: a 2-bit registered `rd_owner` and a `rd_pend` flag capture the granted requester on each issued read. `rd_valid[rd_owner]` = 1 in the following cycle. This holds even if the grant has dropped in that cycle.
- Range check: if `addr_in[g]` ≥ `s_size` while the granted requester strobes read or write:
  - both RAM enables are forced to 0;
  - `addr_err` pulses high next cycle;
  - `rd_valid` is not asserted.
- Simultaneous `rd_en_in[g]` and `wr_en_in[g]`: the write wins, the read is dropped, and no `rd_valid` is generated.
- `rst` in any state: state = IDLE, `grant` = 0, `rr_ptr` = 0, `rd_pend` = 0, `rd_valid` = 0, `addr_err` = 0, all RAM enables = 0. A pending read is discarded.

## Timing
- Request to grant: 1 cycle (`req` seen at edge N, `grant` high after edge N+1). Release to IDLE: 1 cycle.
- Read latency: `rd_valid` rises exactly 1 cycle after `ram_rd_en`, in the same cycle RAM_S drives `q`.
- Back-to-back reads by a granted requester: one per cycle, with `rd_valid` in every cycle after the first.
- RAM-side outputs are combinational from registered `grant` and requester inputs. `grant`, `rd_valid` and `addr_err` are registered.

## Configuration
`ARB_BURST_LIMIT_EN`:
- When defined: a burst counter increments each BUSY cycle while any other `req` bit is high. When the counter reaches `max_burst`:
  - the grant is forcibly dropped and the state returns to IDLE;
  - `rr_ptr` advances past g;
  - the counter clears on every return to IDLE.
  - The preempted requester keeps `req` high and is regranted in its round-robin turn.
- When undefined: a grant is held until the owner drops `req`, with no counter logic.

## Structure
- Shared package `poly_pkg` holds:
  - requester index constants `REQ_STP` = 0, `REQ_EVP` = 1, `REQ_EVB` = 2, and `N_REQ` = 3;
  - the state encoding constants (`ARB_IDLE`, `ARB_BUSY`);
  - the `log2` function.
- One sub-module, `rr_picker`: combinational 3-way round-robin priority pick from `req` and `rr_ptr`, returning a one-hot winner and a valid flag.

## Test plan
- Reset, then `req` = 3'b010 -> `grant` = 3'b010 one cycle later. EVP reads address 5 -> `ram_rd_en` = 1, `ram_addr` = 5, and `rd_valid` = 3'b010 on the next cycle.
- `req` = 3'b111 from IDLE with `rr_ptr` = 0 -> grants in order STP, EVP, EVB, each separated by one IDLE cycle, after each owner drops `req`.
- STP granted and EVB strobes `wr_en_in[2]` with address 3 -> `ram_wr_en` follows STP only, and RAM address 3 is not written by EVB.
- Granted EVP reads address 88 -> `ram_rd_en` = 0, `addr_err` pulses once, `rd_valid` stays 0.
- EVP issues a read and drops `req` in the same cycle -> `rd_valid[1]` = 1 on the next cycle while `grant` = 0.
- With `ARB_BURST_LIMIT_EN` defined and `max_burst` = 4: STP holds `req` while EVP requests -> STP preempted after 4 cycles and EVP granted 2 cycles later. Without the macro, STP keeps the grant indefinitely.
- `rst` asserted mid-BUSY with a read pending -> next cycle `grant` = 0 and `rd_valid` = 0; the following grant starts from STP.

Source files
------------

// File: rtl/poly_pkg.sv
// Shared definitions for the firing-state controller RAM_S arbitration.
// Contents: requester indices, arbiter state encoding, ceil-log2 helper.
// Used by: rr_picker, coeff_ram_arbiter (import poly_pkg::*).
package poly_pkg;

  localparam int REQ_STP = 0;
  localparam int REQ_EVP = 1;
  localparam int REQ_EVB = 2;
  localparam int N_REQ   = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Ceiling log2; log2(88) = 7, log2(17) = 5.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/coeff_ram_arbiter_rr_picker.sv
// rr_picker: combinational 3-way round-robin priority pick.
// Ports: i_req (request bits), i_ptr (first index to search),
//        o_win (one-hot winner), o_vld (some request was present).
module rr_picker
  import poly_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [1:0]       i_ptr,
  output logic [N_REQ-1:0] o_win,
  output logic             o_vld
);

  always_comb begin
    o_win = '0;
    o_vld = 1'b0;
    // Walk the requesters starting at i_ptr, wrapping at N_REQ; first hit wins.
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_vld && i_req[(int'(i_ptr) + k) % N_REQ]) begin
        o_win[(int'(i_ptr) + k) % N_REQ] = 1'b1;
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coeff_ram_arbiter.sv
// coeff_ram_arbiter: shares RAM_S between STP (writes), EVP and EVB (reads)
// with a registered request/grant handshake and round-robin fairness.
// Ports: clk/rst, per-requester req/addr_in/rd_en_in/wr_en_in/wr_data_in,
//        one-hot grant, rd_valid strobes, RAM_S port, addr_err pulse.
// Option: define ARB_BURST_LIMIT_EN to preempt a grant after max_burst
//         contended cycles; otherwise a grant lasts until req drops.
module coeff_ram_arbiter
  import poly_pkg::*;
#(
  parameter int word_size = 16,
  parameter int s_size    = 88,
  parameter int max_burst = 16,
  localparam int aw       = log2(s_size)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*aw-1:0]        addr_in,
  input  logic [N_REQ-1:0]           rd_en_in,
  input  logic [N_REQ-1:0]           wr_en_in,
  input  logic [N_REQ*word_size-1:0] wr_data_in,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           rd_valid,
  output logic [aw-1:0]              ram_addr,
  output logic                       ram_rd_en,
  output logic                       ram_wr_en,
  output logic [word_size-1:0]       ram_wr_data,
  output logic                       addr_err
);

  arb_state_t       r_state;
  logic [N_REQ-1:0] r_grant;
  logic [1:0]       r_rr_ptr;
  logic [1:0]       r_rd_owner;
  logic             r_rd_pend;
  logic             r_addr_err;

  logic [N_REQ-1:0]     w_pick;
  logic                 w_pick_vld;
  logic                 w_busy;
  logic [1:0]           w_g;
  logic [aw-1:0]        w_addr;
  logic                 w_rd;
  logic                 w_wr;
  logic [word_size-1:0] w_wdata;
  logic                 w_oor;
  logic                 w_strobe;
  logic                 w_req_g;
  logic                 w_preempt;

  rr_picker u_rr_picker (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_win (w_pick),
    .o_vld (w_pick_vld)
  );

  assign w_busy = (r_state == ARB_BUSY);

  // Mux the granted requester onto the RAM side; the grant is one-hot.
  always_comb begin
    w_g     = 2'(REQ_STP);
    w_addr  = '0;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_busy && r_grant[i]) begin
        w_g     = 2'(i);
        w_addr  = addr_in[i*aw +: aw];
        w_rd    = rd_en_in[i];
        w_wr    = wr_en_in[i];
        w_wdata = wr_data_in[i*word_size +: word_size];
      end
    end
  end

  assign w_req_g  = |(req & r_grant);
  assign w_oor    = int'(w_addr) >= s_size;
  assign w_strobe = w_busy && !rst && (w_rd || w_wr);

  // Write wins over a simultaneous read; out-of-range accesses issue nothing.
  assign ram_wr_en   = w_strobe && w_wr && !w_oor;
  assign ram_rd_en   = w_strobe && w_rd && !w_wr && !w_oor;
  assign ram_addr    = w_addr;
  assign ram_wr_data = w_wdata;

`ifdef ARB_BURST_LIMIT_EN
  localparam int cw = log2(max_burst + 1);
  logic [cw-1:0] r_burst_cnt;
  logic          w_others;

  assign w_others  = |(req & ~r_grant);
  assign w_preempt = w_busy && w_others && (int'(r_burst_cnt) + 1 >= max_burst);

  // Counts contended BUSY cycles; cleared whenever the grant is not held.
  always_ff @(posedge clk) begin
    if (rst || !w_busy || !w_req_g || w_preempt) begin
      r_burst_cnt <= '0;
    end else if (w_others) begin
      r_burst_cnt <= r_burst_cnt + 1'b1;
    end
  end
`else
  // Without the limit a grant is only released by its owner; a non-positive
  // limit has no meaning, so this is constant zero for any legal setting.
  assign w_preempt = (max_burst < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= 2'(REQ_STP);
      r_rd_owner <= 2'(REQ_STP);
      r_rd_pend  <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      // Read data appears one cycle after ram_rd_en, independent of the grant.
      r_rd_pend  <= ram_rd_en;
      r_rd_owner <= w_g;
      r_addr_err <= w_strobe && w_oor;
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_vld) begin
            r_state <= ARB_BUSY;
            r_grant <= w_pick;
          end
        end
        ARB_BUSY: begin
          if (!w_req_g || w_preempt) begin
            r_state  <= ARB_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= (w_g == 2'(REQ_EVB)) ? 2'(REQ_STP) : w_g + 2'd1;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  always_comb begin
    rd_valid = '0;
    if (r_rd_pend) rd_valid[r_rd_owner] = 1'b1;
  end

  assign grant    = r_grant;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_coeff_ram_arbiter.sv
// Bench for coeff_ram_arbiter: directed scenarios then randomized traffic,
// all checked every cycle against a per-requester behavioural model.
module tb_coeff_ram_arbiter;

  localparam int AW = 7;
  localparam int WS = 16;
  localparam int SS = 88;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req;
  logic [3*AW-1:0] addr_in;
  logic [2:0]    rd_en_in;
  logic [2:0]    wr_en_in;
  logic [3*WS-1:0] wr_data_in;
  logic [2:0]    grant;
  logic [2:0]    rd_valid;
  logic [AW-1:0] ram_addr;
  logic          ram_rd_en;
  logic          ram_wr_en;
  logic [WS-1:0] ram_wr_data;
  logic          addr_err;

  int checks   = 0;
  int failures = 0;

  // Model: owner index (-1 = nobody), next search start, burst count,
  // and the registered outputs expected in the current cycle.
  int       m_owner = -1;
  int       m_ptr   = 0;
  int       m_cnt   = 0;
  logic [2:0] m_rdv = 3'b000;
  logic     m_err   = 1'b0;

  always #5 clk = ~clk;

  coeff_ram_arbiter #(
    .word_size (WS),
    .s_size    (SS),
    .max_burst (MB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .addr_in     (addr_in),
    .rd_en_in    (rd_en_in),
    .wr_en_in    (wr_en_in),
    .wr_data_in  (wr_data_in),
    .grant       (grant),
    .rd_valid    (rd_valid),
    .ram_addr    (ram_addr),
    .ram_rd_en   (ram_rd_en),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_data (ram_wr_data),
    .addr_err    (addr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int i, input logic [AW-1:0] a, input logic rd,
                          input logic wr, input logic [WS-1:0] d);
    addr_in[i*AW +: AW]    = a;
    rd_en_in[i]            = rd;
    wr_en_in[i]            = wr;
    wr_data_in[i*WS +: WS] = d;
  endtask

  task automatic release_owner();
    m_ptr   = (m_owner + 1) % 3;
    m_owner = -1;
    m_cnt   = 0;
  endtask

  // One clock: check everything mid-cycle, then advance the model at the edge.
  task automatic cyc();
    int       g;
    logic [AW-1:0] a;
    bit       rd, wr, oor, erd, ewr, found;
    g = 0; a = '0; rd = 0; wr = 0; oor = 0; erd = 0; ewr = 0; found = 0;
    @(negedge clk);
    chk("grant", {29'd0, grant}, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("rd_valid", {29'd0, rd_valid}, {29'd0, m_rdv});
    chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
    if (m_owner >= 0 && !rst) begin
      g   = m_owner;
      a   = addr_in[g*AW +: AW];
      rd  = rd_en_in[g];
      wr  = wr_en_in[g];
      oor = (a >= SS);
      ewr = wr && !oor;
      erd = rd && !wr && !oor;
    end
    chk("ram_rd_en", {31'd0, ram_rd_en}, {31'd0, erd});
    chk("ram_wr_en", {31'd0, ram_wr_en}, {31'd0, ewr});
    if (ewr || erd) chk("ram_addr", {25'd0, ram_addr}, {25'd0, a});
    if (ewr) chk("ram_wr_data", {16'd0, ram_wr_data}, {16'd0, wr_data_in[g*WS +: WS]});
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_rdv = 3'b000; m_err = 1'b0;
    end else begin
      m_rdv = erd ? 3'(1 << g) : 3'b000;
      m_err = (m_owner >= 0) && (rd || wr) && oor;
      if (m_owner < 0) begin
        m_cnt = 0;
        for (int k = 0; k < 3; k++) begin
          if (!found && req[(m_ptr + k) % 3]) begin
            m_owner = (m_ptr + k) % 3;
            found   = 1;
          end
        end
      end else if (!req[m_owner]) begin
        release_owner();
      end else begin
        if ((req & ~(3'(1 << m_owner))) != 3'b000) m_cnt++;
`ifdef ARB_BURST_LIMIT_EN
        if (m_cnt >= MB) release_owner();
`endif
      end
    end
    #1;
  endtask

  initial begin
    logic [2:0] rq;
    rst = 1'b1; req = '0; addr_in = '0; rd_en_in = '0; wr_en_in = '0; wr_data_in = '0;
    @(posedge clk); #1;
    cyc();
    chk("reset_grant", {29'd0, grant}, 32'd0);
    rst = 1'b0;

    // EVP alone: grant next cycle, read address 5, rd_valid the cycle after.
    req = 3'b010;
    cyc();
    chk("evp_grant", {29'd0, grant}, 32'h2);
    set_port(1, 7'd5, 1'b1, 1'b0, 16'h0);
    cyc();
    set_port(1, 7'd0, 1'b0, 1'b0, 16'h0);
    chk("evp_rd_valid", {29'd0, rd_valid}, 32'h2);
    req = 3'b000;
    cyc(); cyc();

    // All three request from a fresh reset: STP, EVP, EVB with idle gaps.
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 3'b111;
    cyc(); chk("order_stp", {29'd0, grant}, 32'h1);
    req = 3'b110;
    cyc(); chk("order_gap1", {29'd0, grant}, 32'h0);
    cyc(); chk("order_evp", {29'd0, grant}, 32'h2);
    req = 3'b100;
    cyc(); chk("order_gap2", {29'd0, grant}, 32'h0);
    cyc(); chk("order_evb", {29'd0, grant}, 32'h4);
    req = 3'b000;
    cyc(); cyc();

    // STP granted, EVB strobes a write that must not reach the RAM.
    req = 3'b001;
    cyc();
    set_port(0, 7'd10, 1'b0, 1'b1, 16'hA5A5);
    set_port(2, 7'd3, 1'b0, 1'b1, 16'h1234);
    cyc();
    set_port(0, 7'd10, 1'b0, 1'b0, 16'h0);
    cyc();
    set_port(2, 7'd0, 1'b0, 1'b0, 16'h0);
    req = 3'b000;
    cyc(); cyc();

    // EVP reads out of range: no RAM access, one addr_err pulse, no rd_valid.
    req = 3'b010;
    cyc();
    set_port(1, 7'd88, 1'b1, 1'b0, 16'h0);
    cyc();
    set_port(1, 7'd0, 1'b0, 1'b0, 16'h0);
    chk("oor_err", {31'd0, addr_err}, 32'd1);
    cyc();
    chk("oor_err_once", {31'd0, addr_err}, 32'd0);

    // EVP reads and drops req in the same cycle: rd_valid still arrives.
    set_port(1, 7'd7, 1'b1, 1'b0, 16'h0);
    req = 3'b000;
    cyc();
    set_port(1, 7'd0, 1'b0, 1'b0, 16'h0);
    chk("drop_rd_valid", {29'd0, rd_valid}, 32'h2);
    chk("drop_grant", {29'd0, grant}, 32'h0);
    cyc();

    // STP holds while EVP waits.
    req = 3'b011;
    repeat (13) cyc();
`ifndef ARB_BURST_LIMIT_EN
    chk("stp_hold", {29'd0, grant}, 32'h1);
`endif
    req = 3'b000;
    cyc(); cyc();

    // Reset mid-BUSY with a read pending.
    req = 3'b100;
    cyc();
    set_port(2, 7'd2, 1'b1, 1'b0, 16'h0);
    cyc();
    set_port(2, 7'd0, 1'b0, 1'b0, 16'h0);
    rst = 1'b1;
    cyc();
    chk("rst_grant", {29'd0, grant}, 32'h0);
    chk("rst_rd_valid", {29'd0, rd_valid}, 32'h0);
    rst = 1'b0;
    req = 3'b111;
    cyc();
    chk("rst_first_stp", {29'd0, grant}, 32'h1);

    // Randomized traffic; requests persist for a while like real engines.
    rq = 3'b111;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (rq[i]) rq[i] = ($urandom_range(0, 4) != 0);
        else       rq[i] = ($urandom_range(0, 2) == 0);
        set_port(i, 7'($urandom_range(0, 95)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), 16'($urandom));
      end
      req = rq;
      rst = ($urandom_range(0, 99) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
